// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports, once per
// carrier period, the period and the high time in clk cycles.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rstn         asynchronous active-low reset
//   en           capture enable (synchronizer and filter run regardless)
//   pwm_in       asynchronous PWM input
//   period       cycles between consecutive accepted rising edges
//   high_time    cycles from accepted rise to accepted fall
//   meas_valid   one-cycle pulse, period/high_time just updated
//   stall        counter saturated without seeing an edge
//   stall_level  filtered input level at the moment stall was raised
module pwm_capture #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 meas_valid,
    output logic                 stall,
    output logic                 stall_level
);

    localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FCW-1:0]       FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic [FCW-1:0]         diff_cnt;
    logic                   filt;
    logic                   filt_d;
    logic                   rise;
    logic                   fall;
    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [CNT_WIDTH-1:0]   hi_reg;

    // Metastability synchronizer; the last stage feeds the glitch filter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Glitch filter: accept a new level only after FILT_LEN consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            diff_cnt <= '0;
            filt     <= 1'b0;
        end else if (sync_lvl != filt) begin
            if (diff_cnt == FILT_LAST) begin
                filt     <= sync_lvl;
                diff_cnt <= '0;
            end else begin
                diff_cnt <= diff_cnt + FCW'(1);
            end
        end else begin
            diff_cnt <= '0;
        end
    end

    // Registered edge strobes of the filtered level (fixed latency from pwm_in).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_d <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            filt_d <= filt;
            rise   <= filt & ~filt_d;
            fall   <= ~filt & filt_d;
        end
    end

    // Saturating increment: the counter parks at CNT_MAX.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Measurement FSM. cnt equals the number of cycles since the last
    // accepted rise, so capturing it on a strobe gives the exact spacing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            hi_reg      <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            stall       <= 1'b0;
            stall_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                stall <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        // First rise only starts timing; no result yet.
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            stall <= 1'b0;
                            state <= HIGH;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    HIGH: begin
                        // An edge on the saturating cycle still wins.
                        if (fall) begin
                            hi_reg <= cnt;
                            cnt    <= cnt_inc;
                            state  <= LOW;
                        end else if (cnt == CNT_MAX) begin
                            stall       <= 1'b1;
                            stall_level <= filt;
                            state       <= ARM;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            period     <= cnt;
                            high_time  <= hi_reg;
                            meas_valid <= 1'b1;
                            cnt        <= CNT_ONE;
                            state      <= HIGH;
                        end else if (cnt == CNT_MAX) begin
                            stall       <= 1'b1;
                            stall_level <= filt;
                            state       <= ARM;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: drives PWM segments and compares every
// meas_valid result with a reference built from the accepted edge times.
module tb_pwm_capture;

    localparam int unsigned CNT_WIDTH   = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILT_LEN    = 3;
    localparam int          CNT_MAX     = 65535;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 en;
    logic                 pwm_in;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;
    logic                 meas_valid;
    logic                 stall;
    logic                 stall_level;

    pwm_capture #(
        .CNT_WIDTH  (CNT_WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .stall      (stall),
        .stall_level(stall_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Observed results.
    int got_per[$];
    int got_hi[$];
    int got_cyc[$];

    always @(negedge clk) begin
        if (meas_valid) begin
            got_per.push_back(int'(period));
            got_hi.push_back(int'(high_time));
            got_cyc.push_back(cyc);
        end
    end

    // Reference: results follow from the times of accepted input edges.
    bit acc_lvl;
    bit model_en;
    int last_rise;
    int last_fall;
    int exp_per[$];
    int exp_hi[$];

    function automatic void model_edge(input bit v, input int t);
        acc_lvl = v;
        if (!model_en) return;
        // More than CNT_MAX cycles since the last rise: the measurement stalled.
        if (last_rise >= 0 && t - last_rise > CNT_MAX) last_rise = -1;
        if (v) begin
            if (last_rise >= 0 && last_fall > last_rise) begin
                exp_per.push_back(t - last_rise);
                exp_hi.push_back(last_fall - last_rise);
            end
            last_rise = t;
        end else begin
            last_fall = t;
        end
    endfunction

    // Drive one level for n cycles; pulses shorter than FILT_LEN are filtered.
    task automatic seg(input bit v, input int n);
        pwm_in = v;
        if (n >= int'(FILT_LEN) && v != acc_lvl) model_edge(v, cyc);
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_period(input int p, input int h);
        seg(1'b1, h);
        seg(1'b0, p - h);
    endtask

    task automatic check_meas(input string tag);
        int n;
        check_eq({tag, "_count"}, got_per.size(), exp_per.size());
        n = (got_per.size() < exp_per.size()) ? got_per.size() : exp_per.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_period[%0d]", tag, i), got_per[i], exp_per[i]);
            check_eq($sformatf("%s_high[%0d]", tag, i), got_hi[i], exp_hi[i]);
        end
        got_per.delete();
        got_hi.delete();
        got_cyc.delete();
        exp_per.delete();
        exp_hi.delete();
    endtask

    task automatic model_clear();
        last_rise = -1;
        last_fall = -1;
    endtask

    initial begin
        int p;
        int h;
        rstn   = 1'b0;
        en     = 1'b0;
        pwm_in = 1'b0;
        acc_lvl  = 1'b0;
        model_en = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_period", int'(period), 0);
        check_eq("rst_high", int'(high_time), 0);
        check_eq("rst_valid", int'(meas_valid), 0);
        check_eq("rst_stall", int'(stall), 0);
        check_eq("rst_stall_level", int'(stall_level), 0);
        rstn = 1'b1;
        en = 1'b1;
        model_en = 1'b1;
        seg(1'b0, 10);

        // Steady 100/30: nothing after the first rise, then one result per period.
        pwm_period(100, 30);
        check_eq("t1_first_rise_no_valid", got_per.size(), 0);
        repeat (5) pwm_period(100, 30);
        for (int i = 1; i < got_cyc.size(); i++)
            check_eq($sformatf("t1_spacing[%0d]", i), got_cyc[i] - got_cyc[i-1], 100);
        check_meas("t1");
        check_eq("t1_stall", int'(stall), 0);

        // 2-cycle glitch is rejected, 3-cycle glitch is accepted.
        seg(1'b1, 10); seg(1'b0, 2); seg(1'b1, 18); seg(1'b0, 70);
        pwm_period(100, 30);
        check_meas("t2_short_glitch");
        seg(1'b1, 10); seg(1'b0, 3); seg(1'b1, 17); seg(1'b0, 70);
        pwm_period(100, 30);
        check_meas("t2_long_glitch");

        // Enable dropped mid-LOW: outputs hold, two rises needed afterwards.
        seg(1'b1, 30);
        seg(1'b0, 20);
        en = 1'b0;
        model_en = 1'b0;
        model_clear();
        seg(1'b0, 10);
        check_eq("t4_hold_period", int'(period), 100);
        check_eq("t4_hold_high", int'(high_time), 30);
        check_eq("t4_stall", int'(stall), 0);
        en = 1'b1;
        model_en = 1'b1;
        seg(1'b0, 40);
        pwm_period(100, 30);
        seg(1'b1, 30);
        check_meas("t4");
        seg(1'b0, 70);

        // Input stuck high past counter saturation.
        pwm_period(100, 30);
        seg(1'b1, 65000);
        check_eq("t3_no_stall_yet", int'(stall), 0);
        seg(1'b1, 5000);
        check_eq("t3_stall", int'(stall), 1);
        check_eq("t3_stall_level", int'(stall_level), 1);
        check_eq("t3_hold_period", int'(period), 100);
        check_eq("t3_hold_high", int'(high_time), 30);
        seg(1'b0, 70);
        check_eq("t3_stall_until_rise", int'(stall), 1);
        seg(1'b1, 30);
        check_eq("t3_stall_cleared", int'(stall), 0);
        seg(1'b0, 70);
        seg(1'b1, 30);
        check_meas("t3");

        // Asynchronous reset mid-HIGH.
        seg(1'b0, 70);
        seg(1'b1, 15);
        check_meas("t5_pre");
        #2;
        rstn = 1'b0;
        en   = 1'b0;
        #1;
        check_eq("t5_async_period", int'(period), 0);
        check_eq("t5_async_high", int'(high_time), 0);
        check_eq("t5_async_valid", int'(meas_valid), 0);
        check_eq("t5_async_stall", int'(stall), 0);
        check_eq("t5_async_stall_level", int'(stall_level), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        // Filter restarts from 0 and will accept the still-high input.
        model_en = 1'b0;
        model_clear();
        acc_lvl = 1'b0;
        seg(1'b1, 13);
        seg(1'b0, 30);
        check_eq("t5_idle_period", int'(period), 0);
        check_eq("t5_idle_stall", int'(stall), 0);
        en = 1'b1;
        model_en = 1'b1;
        seg(1'b0, 40);
        pwm_period(100, 30);
        pwm_period(100, 30);
        seg(1'b1, 30);
        check_meas("t5");
        seg(1'b0, 70);

        // Duty extremes at period 50; low of 1 cycle is below the filter length.
        repeat (3) pwm_period(50, 47);
        check_meas("t6_47");
        repeat (3) pwm_period(50, 4);
        check_meas("t6_4");
        repeat (3) pwm_period(50, 3);
        check_meas("t6_3");
        repeat (4) pwm_period(50, 49);
        repeat (2) pwm_period(50, 47);
        check_meas("t6_49");

        // Randomized period/high pairs.
        for (int k = 0; k < 12; k++) begin
            p = int'($urandom_range(200, 20));
            h = int'($urandom_range(p - int'(FILT_LEN), int'(FILT_LEN)));
            repeat (3) pwm_period(p, h);
            check_meas($sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
